// File: rtl/kd_pkg.sv
// Shared kd-tree sort definitions: sequencer states, node depth and CE parity masks.
// Combinational helpers only; no latency and no flow control.
package kd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FIRE_EVEN,
    SETTLE_EVEN,
    FIRE_ODD,
    SETTLE_ODD,
    EVAL,
    DONE
  } kd_state_t;

  localparam int KD_MAX_CE = 64;

  // floor(log2(idx+1)) with fixed loop bounds so it also elaborates as a constant
  function automatic int kd_depth(input int idx);
    int d;
    d = 0;
    for (int k = 1; k < 31; k++) begin
      if (((idx + 1) >> k) != 0) d = k;
    end
    return d;
  endfunction

  function automatic logic [KD_MAX_CE-1:0] kd_parity_mask(input int levels, input logic odd);
    logic [KD_MAX_CE-1:0] mask;
    int num_ce;
    int d;
    mask   = '0;
    num_ce = (1 << (levels - 1)) - 1;
    for (int i = 0; i < KD_MAX_CE; i++) begin
      d = kd_depth(i);
      if (i < num_ce && (((d & 1) != 0) == odd)) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/kd_level_mask.sv
// Constant even/odd depth masks for the compare-exchange elements of a LEVELS-deep tree.
// Pure constants; zero latency, no backpressure.
module kd_level_mask
  import kd_pkg::*;
#(
  parameter int LEVELS = 3
) (
  output logic [(2**(LEVELS-1))-2:0] even_mask,
  output logic [(2**(LEVELS-1))-2:0] odd_mask
);

  localparam int NUM_CE = (2**(LEVELS-1)) - 1;
  localparam logic [KD_MAX_CE-1:0] EVEN_ALL = kd_parity_mask(LEVELS, 1'b0);
  localparam logic [KD_MAX_CE-1:0] ODD_ALL  = kd_parity_mask(LEVELS, 1'b1);

  assign even_mask = EVEN_ALL[NUM_CE-1:0];
  assign odd_mask  = ODD_ALL[NUM_CE-1:0];

endmodule

// File: rtl/kd_sort_sequencer.sv
// Odd/even compare-exchange pass sequencer for a kd-tree sort; 5 cycles per pass, done P*5+1 after start.
// No backpressure: start is ignored while busy, abort wins everywhere; KD_SORT_STATS_EN adds swap_cnt.
module kd_sort_sequencer
  import kd_pkg::*;
#(
  parameter int LEVELS     = 3,
  parameter int MAX_PASSES = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                abort,
  input  logic [(2**(LEVELS-1))-2:0]          stable_in,
  output logic [(2**(LEVELS-1))-2:0]          ce_en,
  output logic                                sorting,
  output logic                                busy,
  output logic                                done,
  output logic                                timeout,
  output logic [$clog2(MAX_PASSES+1)-1:0]     pass_cnt
`ifdef KD_SORT_STATS_EN
  ,
  output logic [15:0]                         swap_cnt
`endif
);

  localparam int NUM_CE = (2**(LEVELS-1)) - 1;
  localparam int PW     = $clog2(MAX_PASSES+1);

  logic [NUM_CE-1:0] even_mask;
  logic [NUM_CE-1:0] odd_mask;
  kd_state_t         state;
  logic              swap_flag;
  logic [PW-1:0]     next_cnt;

  kd_level_mask #(.LEVELS(LEVELS)) u_mask (
    .even_mask (even_mask),
    .odd_mask  (odd_mask)
  );

  assign next_cnt = pass_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ce_en     <= '0;
      sorting   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      pass_cnt  <= '0;
      swap_flag <= 1'b0;
    end else if (abort && state != IDLE) begin
      state   <= IDLE;
      ce_en   <= '0;
      sorting <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state     <= FIRE_EVEN;
            ce_en     <= even_mask;
            sorting   <= 1'b1;
            busy      <= 1'b1;
            timeout   <= 1'b0;
            pass_cnt  <= '0;
            swap_flag <= 1'b0;
          end
        end
        FIRE_EVEN: begin
          swap_flag <= swap_flag | (|(~stable_in & even_mask));
          ce_en     <= '0;
          sorting   <= 1'b0;
          state     <= SETTLE_EVEN;
        end
        SETTLE_EVEN: begin
          // odd mask may be empty for shallow trees; the slot still runs
          ce_en   <= odd_mask;
          sorting <= 1'b1;
          state   <= FIRE_ODD;
        end
        FIRE_ODD: begin
          swap_flag <= swap_flag | (|(~stable_in & odd_mask));
          ce_en     <= '0;
          sorting   <= 1'b0;
          state     <= SETTLE_ODD;
        end
        SETTLE_ODD: state <= EVAL;
        EVAL: begin
          pass_cnt <= next_cnt;
          if (!swap_flag) begin
            state   <= DONE;
            done    <= 1'b1;
            timeout <= 1'b0;
          end else if (next_cnt == PW'(MAX_PASSES)) begin
            state   <= DONE;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            swap_flag <= 1'b0;
            ce_en     <= even_mask;
            sorting   <= 1'b1;
            state     <= FIRE_EVEN;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          ce_en   <= '0;
          sorting <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef KD_SORT_STATS_EN
  function automatic logic [15:0] popcount(input logic [NUM_CE-1:0] v);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < NUM_CE; i++) c = c + 16'(v[i]);
    return c;
  endfunction

  logic [NUM_CE-1:0] fire_mask;
  logic [16:0]       swap_sum;

  always_comb begin
    fire_mask = '0;
    if (state == FIRE_EVEN)     fire_mask = even_mask;
    else if (state == FIRE_ODD) fire_mask = odd_mask;
  end

  assign swap_sum = {1'b0, swap_cnt} + {1'b0, popcount(~stable_in & fire_mask)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      swap_cnt <= '0;
    end else if (state == IDLE && start && !abort) begin
      swap_cnt <= '0;
    end else if (!abort && (state == FIRE_EVEN || state == FIRE_ODD)) begin
      swap_cnt <= swap_sum[16] ? 16'hFFFF : swap_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_kd_sort_sequencer.sv
// Directed bench for kd_sort_sequencer (LEVELS=3, MAX_PASSES=4); swap_cnt checked when KD_SORT_STATS_EN is set.
module tb_kd_sort_sequencer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [2:0] stable_in;
  logic [2:0] ce_en;
  logic       sorting;
  logic       busy;
  logic       done;
  logic       timeout;
  logic [2:0] pass_cnt;
`ifdef KD_SORT_STATS_EN
  logic [15:0] swap_cnt;
`endif

  int vectors;
  int miscompares;
  int cyc;
  int done_seen;

  kd_sort_sequencer #(.LEVELS(3), .MAX_PASSES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .stable_in (stable_in),
    .ce_en     (ce_en),
    .sorting   (sorting),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .pass_cnt  (pass_cnt)
`ifdef KD_SORT_STATS_EN
    ,
    .swap_cnt  (swap_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // cyc counts edges since the edge that sampled start; bounded wait for done
  task automatic wait_done(input int limit);
    while (!done && cyc < limit) begin
      tick();
      cyc++;
    end
    if (!done) begin
      miscompares++;
      $error("FAIL wait_done timed out after %0d cycles", cyc);
    end
  endtask

  task automatic kick(input logic [2:0] stab);
    start     = 1'b1;
    stable_in = stab;
    tick();
    start = 1'b0;
    cyc   = 1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    stable_in   = 3'b111;
    #3;
    check("rst_busy", busy, 0);
    check("rst_ce_en", ce_en, 0);
    check("rst_done", done, 0);
    check("rst_pass_cnt", pass_cnt, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // single converged pass
    kick(3'b111);
    check("a_fe_ce_en", ce_en, 3'b001);
    check("a_fe_sorting", sorting, 1);
    check("a_fe_busy", busy, 1);
    tick(); cyc++;
    check("a_se_ce_en", ce_en, 3'b000);
    check("a_se_sorting", sorting, 0);
    tick(); cyc++;
    check("a_fo_ce_en", ce_en, 3'b110);
    tick(); cyc++;
    tick(); cyc++;
    check("a_eval_done", done, 0);
    wait_done(40);
    check("a_done_cycle", cyc, 6);
    check("a_timeout", timeout, 0);
    check("a_pass_cnt", pass_cnt, 1);
    tick();
    check("a_done_pulse", done, 0);
    check("a_idle_busy", busy, 0);
    check("a_hold_pass", pass_cnt, 1);

    // one unstable CE in the first even fire only
    kick(3'b110);
    tick(); cyc++;
    stable_in = 3'b111;
    wait_done(60);
    check("b_done_cycle", cyc, 11);
    check("b_pass_cnt", pass_cnt, 2);
    check("b_timeout", timeout, 0);
    tick();

    // never converges: timeout at MAX_PASSES
    kick(3'b000);
    wait_done(100);
    check("c_done_cycle", cyc, 21);
    check("c_timeout", timeout, 1);
    check("c_pass_cnt", pass_cnt, 4);
    tick();
    check("c_done_pulse", done, 0);
    check("c_hold_timeout", timeout, 1);

    // start with abort in IDLE is ignored
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("d_start_abort_idle", busy, 0);

    // abort from SETTLE_EVEN
    kick(3'b111);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("d_abort_busy", busy, 0);
    check("d_abort_ce_en", ce_en, 0);
    check("d_abort_done", done, 0);
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) done_seen++;
    end
    check("d_no_done", done_seen, 0);
    kick(3'b111);
    wait_done(40);
    check("d_rerun_cycle", cyc, 6);
    check("d_rerun_timeout", timeout, 0);
    tick();

    // start while busy is ignored, then async reset mid-FIRE_ODD
    kick(3'b000);
    for (int i = 0; i < 5; i++) begin
      tick(); cyc++;
    end
    check("e_pass2_cnt", pass_cnt, 1);
    start = 1'b1;
    tick(); cyc++;
    start = 1'b0;
    check("e_busy_start_cnt", pass_cnt, 1);
    check("e_busy_start_busy", busy, 1);
    tick(); cyc++;
    check("e_fo_ce_en", ce_en, 3'b110);
    #2;
    rst = 1'b1;
    #1;
    check("e_rst_ce_en", ce_en, 0);
    check("e_rst_sorting", sorting, 0);
    check("e_rst_busy", busy, 0);
    check("e_rst_pass_cnt", pass_cnt, 0);
    tick();
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) done_seen++;
    end
    check("e_no_done_after_rst", done_seen, 0);

`ifdef KD_SORT_STATS_EN
    // three swaps in pass one, none in pass two
    kick(3'b000);
    tick(); cyc++;
    tick(); cyc++;
    tick(); cyc++;
    stable_in = 3'b111;
    wait_done(60);
    check("f_done_cycle", cyc, 11);
    check("f_swap_cnt", swap_cnt, 3);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/kd_sort_sequencer.md
KD_SORT_SEQUENCER -- requirements
Module: kd_sort_sequencer

Interface
- REQ-001 SHALL have parameter LEVELS, default 3, giving the tree depth; the tree has 2^LEVELS-1 nodes and NUM_CE = 2^(LEVELS-1)-1 compare-exchange elements, indexed in heap order (root = 0).
- REQ-002 SHALL have parameter MAX_PASSES, default 16, giving the pass limit before timeout.
- REQ-003 clk  input  1  single clock; all state changes on its rising edge.
- REQ-004 rst  input  1  asynchronous, active-high reset.
- REQ-005 start  input  1  one-cycle request to begin sorting; sampled only in IDLE.
- REQ-006 abort  input  1  force return to IDLE.
- REQ-007 stable_in  input  NUM_CE  per-CE stable flag, combinational from each CE's current operands.
- REQ-008 ce_en  output  NUM_CE  per-CE enable.
- REQ-009 sorting  output  1  sort-mode select to all CEs.
- REQ-010 busy  output  1  high outside IDLE.
- REQ-011 done  output  1  one-cycle completion pulse.
- REQ-012 timeout  output  1  valid with done; high when MAX_PASSES was reached without convergence.
- REQ-013 pass_cnt  output  clog2(MAX_PASSES+1)  number of completed passes.

Function
- REQ-014 CE i SHALL have depth floor(log2(i+1)); EVEN_MASK SHALL select CEs of even depth and ODD_MASK CEs of odd depth, so CEs firing together never share a node.
- REQ-015 FSM states SHALL be IDLE, FIRE_EVEN, SETTLE_EVEN, FIRE_ODD, SETTLE_ODD, EVAL, DONE.
- REQ-016 IDLE with start=1 SHALL go to FIRE_EVEN, clearing pass_cnt and the pass-swap flag.
- REQ-017 In FIRE_EVEN and FIRE_ODD, ce_en SHALL equal EVEN_MASK or ODD_MASK respectively and sorting SHALL be 1; in every other state ce_en SHALL be 0 and sorting SHALL be 0.
- REQ-018 In each FIRE state, the pass-swap flag SHALL be set if (~stable_in & active mask) != 0; stable_in SHALL be ignored in all other states.
- REQ-019 FIRE_x SHALL go to SETTLE_x unconditionally; SETTLE_EVEN SHALL go to FIRE_ODD; SETTLE_ODD SHALL go to EVAL. Each SETTLE state is one cycle for the node registers to load.
- REQ-020 When LEVELS < 3, ODD_MASK is empty; FIRE_ODD/SETTLE_ODD SHALL still execute with ce_en = 0.
- REQ-021 EVAL SHALL increment pass_cnt, then: swap flag clear -> DONE with timeout=0; otherwise, if the incremented pass_cnt equals MAX_PASSES -> DONE with timeout=1; otherwise clear the swap flag and go to FIRE_EVEN.
- REQ-022 DONE SHALL assert done for exactly one cycle, hold timeout, and return to IDLE; timeout and pass_cnt SHALL hold until the next start.
- REQ-023 A full pass SHALL take 5 cycles; a converged run of P passes SHALL assert done P*5+1 cycles after start is sampled.
- REQ-024 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with done=0 and ce_en=0 from that edge; abort SHALL take priority over all transitions. start together with abort in IDLE SHALL be ignored.
- REQ-025 start while busy SHALL be ignored.

Reset
- REQ-026 rst SHALL force state IDLE, ce_en=0, sorting=0, busy=0, done=0, timeout=0, pass_cnt=0 and swap flag=0, regardless of clock; reset during a pass SHALL abandon that pass with no done pulse.

Configuration
- REQ-027 With KD_SORT_STATS_EN defined, the block SHALL add output swap_cnt, 16 bits: cleared on start, incremented by popcount(~stable_in & mask) in each FIRE state, saturating at 0xFFFF. Without the macro, the port and its logic SHALL be absent and behaviour SHALL be otherwise identical.

Structure
- REQ-028 The shared package kd_pkg SHALL hold the FSM state enum, the depth function, and the EVEN/ODD mask generator constants, for reuse by the future tree top level.
- REQ-029 One sub-module, kd_level_mask (parameter LEVELS, outputs even_mask/odd_mask), SHALL be used; all other logic SHALL be flat.

Verification
- REQ-030 LEVELS=3, stable_in=3'b111 always, start -> ce_en 3'b001 then 3'b110; done 6 cycles after start with timeout=0 and pass_cnt=1.
- REQ-031 LEVELS=3, stable_in bit0=0 in the first FIRE_EVEN only -> two passes; done at cycle 11 with pass_cnt=2 and timeout=0.
- REQ-032 MAX_PASSES=4, stable_in=3'b000 always -> done at cycle 21 with timeout=1 and pass_cnt=4.
- REQ-033 abort asserted in SETTLE_EVEN -> busy=0 and ce_en=0 on the next edge, with no done pulse; a following start runs normally.
- REQ-034 rst asserted mid-FIRE_ODD, asynchronous to clk -> all outputs go to 0 immediately; start pulses while busy produce no restart (pass_cnt is not cleared).
- REQ-035 With KD_SORT_STATS_EN, stable_in=3'b000 for one pass, then 3'b111 -> swap_cnt=3 at done.
